// File: rtl/dma_engine.sv
// Row/column DMA engine: streams N A-rows and N B-columns out of memory, then
// writes N C-rows back. Optional busy-cycle counter enabled by `define DMA_PERF_EN.
module dma_engine #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     a_base,
  input  logic [31:0]     b_base,
  input  logic [31:0]     c_base,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [31:0]     mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            a_valid,
  input  logic            a_ready,
  output logic [N*8-1:0]  a_row,
  output logic            b_valid,
  input  logic            b_ready,
  output logic [N*8-1:0]  b_col,
  input  logic            c_valid,
  output logic            c_ready,
  input  logic [N*16-1:0] c_row,
  output logic [31:0]     perf_cycles
);

  localparam int unsigned AB = N * 8 / DW;
  localparam int unsigned CB = N * 16 / DW;
  localparam int unsigned JW = $clog2(CB) + 1;
  localparam int unsigned KW = $clog2(N) + 1;

  localparam logic [JW-1:0] A_LAST  = JW'(AB - 1);
  localparam logic [JW-1:0] C_LAST  = JW'(CB - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(N - 1);
  localparam logic [31:0]   AB_ROWB = 32'(N);
  localparam logic [31:0]   C_ROWB  = 32'(2 * N);
  localparam logic [31:0]   BEAT_B  = 32'(DW / 8);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_A   = 3'd1;
  localparam logic [2:0] PUSH_A = 3'd2;
  localparam logic [2:0] RD_B   = 3'd3;
  localparam logic [2:0] PUSH_B = 3'd4;
  localparam logic [2:0] GET_C  = 3'd5;
  localparam logic [2:0] WR_C   = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  logic [2:0]      state;
  logic [KW-1:0]   k;
  logic [JW-1:0]   j;
  logic            rd_wait;
  logic [31:0]     a_base_q;
  logic [31:0]     b_base_q;
  logic [31:0]     c_base_q;
  logic [N*16-1:0] c_buf;
  logic [31:0]     beat_addr;
  logic            misaligned;
  logic            accept;

  assign misaligned = |{a_base[2:0], b_base[2:0], c_base[2:0]};
  assign accept     = start && (state == IDLE) && !misaligned;

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign a_valid = (state == PUSH_A);
  assign b_valid = (state == PUSH_B);
  assign c_ready = (state == GET_C);

  always_comb begin
    beat_addr = '0;
    case (state)
      RD_A:    beat_addr = a_base_q + 32'(k) * AB_ROWB + 32'(j) * BEAT_B;
      RD_B:    beat_addr = b_base_q + 32'(k) * AB_ROWB + 32'(j) * BEAT_B;
      default: beat_addr = c_base_q + 32'(k) * C_ROWB + 32'(j) * BEAT_B;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      j         <= '0;
      rd_wait   <= 1'b0;
      a_base_q  <= '0;
      b_base_q  <= '0;
      c_base_q  <= '0;
      c_buf     <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_row     <= '0;
      b_col     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (misaligned) begin
              err <= 1'b1;
            end else begin
              err      <= 1'b0;
              a_base_q <= a_base;
              b_base_q <= b_base;
              c_base_q <= c_base;
              k        <= '0;
              j        <= '0;
              state    <= RD_A;
            end
          end
        end
        RD_A, RD_B: begin
          // Single outstanding read: request, drop req on grant, wait for rvalid.
          if (mem_req) begin
            if (mem_gnt) begin
              mem_req <= 1'b0;
              rd_wait <= 1'b1;
            end
          end else if (rd_wait) begin
            if (mem_rvalid) begin
              rd_wait <= 1'b0;
              if (state == RD_A) a_row[j*DW +: DW] <= mem_rdata;
              else               b_col[j*DW +: DW] <= mem_rdata;
              if (j == A_LAST) begin
                j     <= '0;
                state <= (state == RD_A) ? PUSH_A : PUSH_B;
              end else begin
                j <= j + 1'b1;
              end
            end
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= beat_addr;
          end
        end
        PUSH_A: begin
          if (a_ready) begin
            if (k == K_LAST) begin
              k     <= '0;
              state <= RD_B;
            end else begin
              k     <= k + 1'b1;
              state <= RD_A;
            end
          end
        end
        PUSH_B: begin
          if (b_ready) begin
            if (k == K_LAST) begin
              k     <= '0;
              state <= GET_C;
            end else begin
              k     <= k + 1'b1;
              state <= RD_B;
            end
          end
        end
        GET_C: begin
          if (c_valid) begin
            c_buf <= c_row;
            state <= WR_C;
          end
        end
        WR_C: begin
          if (mem_req) begin
            if (mem_gnt) begin
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              if (j == C_LAST) begin
                j <= '0;
                if (k == K_LAST) begin
                  k     <= '0;
                  state <= DONE;
                end else begin
                  k     <= k + 1'b1;
                  state <= GET_C;
                end
              end else begin
                j <= j + 1'b1;
              end
            end
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= beat_addr;
            mem_wdata <= c_buf[j*DW +: DW];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMA_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: expected reads, rows, columns and C writes are
// queued at job launch and popped as the engine produces them.
module tb_dma_engine;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 64;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [31:0]     a_base, b_base, c_base;
  logic            busy, done, err;
  logic            mem_req, mem_gnt, mem_we;
  logic [31:0]     mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            a_valid, a_ready, b_valid, b_ready, c_valid, c_ready;
  logic [N*8-1:0]  a_row, b_col;
  logic [N*16-1:0] c_row;
  logic [31:0]     perf_cycles;

  logic            rvalid_r;
  logic [DW-1:0]   rdata_r;
  int              c_cnt;
  int              busy_cnt;
  int              done_cnt;
  int              n_chk;
  int              n_pass;

  logic [31:0] rd_q[$];
  logic [63:0] a_q[$];
  logic [63:0] b_q[$];
  logic [31:0] wa_q[$];
  logic [63:0] wd_q[$];

  dma_engine #(.N(N), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a_base      (a_base),
    .b_base      (b_base),
    .c_base      (c_base),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_req     (mem_req),
    .mem_gnt     (mem_gnt),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_row       (a_row),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_col       (b_col),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .c_row       (c_row),
    .perf_cycles (perf_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] mem_pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_A5A5, a};
  endfunction

  function automatic logic [127:0] c_pat(input int r);
    logic [31:0] rr;
    rr = 32'(r);
    return {32'hC0DE_0000 + rr, 32'h1111_0000 + rr, 32'h2222_0000 + rr, 32'h3333_0000 + rr};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory: one-cycle read latency after grant.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
    end else begin
      rvalid_r <= mem_req && mem_gnt && !mem_we;
      rdata_r  <= mem_pat(mem_addr);
    end
  end
  assign mem_rvalid = rvalid_r;
  assign mem_rdata  = rdata_r;

  always @(posedge clk) begin
    if (start) c_cnt <= 0;
    else if (c_valid && c_ready) c_cnt <= c_cnt + 1;
  end
  assign c_row = c_pat(c_cnt);

  // Output monitor, sampled just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (a_valid && a_ready) begin
        if (a_q.size() == 0) check("a_extra", 128'(1), 128'(0));
        else check("a_row", 128'(a_row), 128'(a_q.pop_front()));
      end
      if (b_valid && b_ready) begin
        if (b_q.size() == 0) check("b_extra", 128'(1), 128'(0));
        else check("b_col", 128'(b_col), 128'(b_q.pop_front()));
      end
      if (mem_req && mem_gnt) begin
        if (mem_we) begin
          if (wa_q.size() == 0) check("wr_extra", 128'(1), 128'(0));
          else begin
            check("wr_addr", 128'(mem_addr), 128'(wa_q.pop_front()));
            check("wr_data", 128'(mem_wdata), 128'(wd_q.pop_front()));
          end
        end else begin
          if (rd_q.size() == 0) check("rd_extra", 128'(1), 128'(0));
          else check("rd_addr", 128'(mem_addr), 128'(rd_q.pop_front()));
        end
      end
    end
  end

  task automatic push_expect(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [127:0] cp;
    logic [31:0]  ad;
    for (int r = 0; r < int'(N); r++) begin
      ad = a + 32'(r * 8);
      rd_q.push_back(ad);
      a_q.push_back(mem_pat(ad));
    end
    for (int r = 0; r < int'(N); r++) begin
      ad = b + 32'(r * 8);
      rd_q.push_back(ad);
      b_q.push_back(mem_pat(ad));
    end
    for (int r = 0; r < int'(N); r++) begin
      cp = c_pat(r);
      for (int bt = 0; bt < 2; bt++) begin
        wa_q.push_back(c + 32'(r * 16 + bt * 8));
        wd_q.push_back(cp[bt*64 +: 64]);
      end
    end
  endtask

  task automatic flush_expect();
    rd_q.delete();
    a_q.delete();
    b_q.delete();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic start_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    @(negedge clk);
    a_base   = a;
    b_base   = b;
    c_base   = c;
    start    = 1'b1;
    busy_cnt = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    logic        seen;
    int          d0;
    logic [31:0] p0;
    seen = 1'b0;
    d0   = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 128'(seen), 128'(1));
    @(negedge clk);
    check("done_one_cycle", 128'(done), 128'(0));
    check("busy_after_done", 128'(busy), 128'(0));
    check("rd_q_empty", 128'(rd_q.size()), 128'(0));
    check("a_q_empty", 128'(a_q.size()), 128'(0));
    check("b_q_empty", 128'(b_q.size()), 128'(0));
    check("wr_q_empty", 128'(wa_q.size()), 128'(0));
`ifdef DMA_PERF_EN
    check("perf_cycles", 128'(perf_cycles), 128'(busy_cnt));
`else
    check("perf_zero", 128'(perf_cycles), 128'(0));
`endif
    p0 = perf_cycles;
    repeat (3) @(negedge clk);
    check("perf_stable", 128'(perf_cycles), 128'(p0));
    check("done_pulses", 128'(done_cnt - d0), 128'(1));
    flush_expect();
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    busy_cnt = 0;
    done_cnt = 0;
    c_cnt    = 0;
    start    = 1'b0;
    a_base   = '0;
    b_base   = '0;
    c_base   = '0;
    mem_gnt  = 1'b1;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    c_valid  = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_c_ready", 128'(c_ready), 128'(0));
    check("rst_perf", 128'(perf_cycles), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_req", 128'(mem_req), 128'(0));

    // Nominal job, everything immediate.
    push_expect(32'h1000, 32'h2000, 32'h3000);
    start_job(32'h1000, 32'h2000, 32'h3000);
    wait_done();

    // Misaligned base is rejected, then an aligned start clears err.
    start_job(32'h1003, 32'h2000, 32'h3000);
    check("misalign_err", 128'(err), 128'(1));
    check("misalign_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 4; i++) begin
      check("misalign_no_req", 128'(mem_req), 128'(0));
      @(negedge clk);
    end
    push_expect(32'h1000, 32'h2000, 32'h3000);
    start_job(32'h1000, 32'h2000, 32'h3000);
    check("err_cleared", 128'(err), 128'(0));
    check("busy_on_start", 128'(busy), 128'(1));
    wait_done();

    // Address wrap past 2^32.
    push_expect(32'hFFFF_FFC0, 32'h0000_5000, 32'hFFFF_FFF0);
    start_job(32'hFFFF_FFC0, 32'h0000_5000, 32'hFFFF_FFF0);
    wait_done();

    // Grant withheld on the first A read.
    mem_gnt = 1'b0;
    push_expect(32'h4000, 32'h6000, 32'h8000);
    start_job(32'h4000, 32'h6000, 32'h8000);
    for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_req", 128'(mem_req), 128'(1));
      check("stall_addr", 128'(mem_addr), 128'(32'h4000));
      @(negedge clk);
    end
    mem_gnt = 1'b1;
    wait_done();

    // Backpressure on the A stream.
    a_ready = 1'b0;
    push_expect(32'h1100, 32'h2200, 32'h3300);
    start_job(32'h1100, 32'h2200, 32'h3300);
    for (int i = 0; i < 50 && !a_valid; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("hold_a_valid", 128'(a_valid), 128'(1));
      check("hold_a_row", 128'(a_row), 128'(mem_pat(32'h1100)));
      check("hold_no_req", 128'(mem_req), 128'(0));
      @(negedge clk);
    end
    a_ready = 1'b1;
    wait_done();

    // Reset during beat 1 of C row 3, then restart from row 0.
    push_expect(32'h1000, 32'h2000, 32'h3000);
    start_job(32'h1000, 32'h2000, 32'h3000);
    for (int i = 0; i < 1000; i++) begin
      if (mem_req && mem_we && mem_addr == 32'h3038) break;
      @(negedge clk);
    end
    check("wr_row3_beat1_reached", 128'(mem_addr), 128'(32'h3038));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    check("mid_rst_mem_req", 128'(mem_req), 128'(0));
    check("mid_rst_mem_we", 128'(mem_we), 128'(0));
    check("mid_rst_mem_addr", 128'(mem_addr), 128'(0));
    check("mid_rst_mem_wdata", 128'(mem_wdata), 128'(0));
    check("mid_rst_valids", 128'({a_valid, b_valid, c_ready}), 128'(0));
    check("mid_rst_rows", 128'({a_row, b_col}), 128'(0));
    check("mid_rst_perf", 128'(perf_cycles), 128'(0));
    flush_expect();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_no_req", 128'(mem_req), 128'(0));
      @(negedge clk);
    end
    push_expect(32'h1000, 32'h2000, 32'h3000);
    start_job(32'h1000, 32'h2000, 32'h3000);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
